// File: rtl/tft_lcd_timing_gen.sv
// rtl/tft_lcd_timing_gen.sv - TFT raster timing generator with SOF-aligned RGB888 stream intake
module tft_lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int PCLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic [23:0] i_s_data,
  input  logic        i_s_sof,
  output logic        o_tft_pclk,
  output logic        o_tft_disp,
  output logic        o_tft_hsync,
  output logic        o_tft_vsync,
  output logic        o_tft_de,
  output logic [23:0] o_tft_rgb,
  output logic        o_frame_start,
  output logic        o_err_underflow,
  output logic        o_err_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;

  localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] C_V_LAST = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] C_D_LAST = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] C_D_HALF = DW'(PCLK_DIV / 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEEK   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_pclk;
  logic          r_disp;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [23:0]   r_rgb;
  logic          r_frame_start;
  logic          r_err_underflow;
  logic          r_err_sync;

  logic [1:0] w_state_nxt;
  logic       w_run;
  logic       w_pt;
  logic       w_first;
  logic       w_active;
  logic       w_take;
  logic       w_drain;
  logic       w_under;
  logic       w_serr;

  // Counters only run once the FSM has left IDLE, so the first pixel tick is h=0,v=0.
  assign w_run    = i_en && (r_state != ST_IDLE);
  assign w_pt     = w_run && (r_div == '0);
  assign w_first  = (r_h == '0) && (r_v == '0);
  assign w_active = (r_h < C_H_ACT) && (r_v < C_V_ACT);

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_drain     = 1'b0;
    w_under     = 1'b0;
    w_serr      = 1'b0;
    if (i_rst || !i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_SEEK;
        ST_SEEK: begin
          if (w_pt && w_first && i_s_valid && i_s_sof) begin
            w_take      = 1'b1;
            w_state_nxt = ST_STREAM;
          end else if (i_s_valid && !i_s_sof) begin
            w_drain = 1'b1;
          end
        end
        ST_STREAM: begin
          // A misplaced SOF head is left in place so SEEK can pick it up at the next frame.
          if (w_pt && w_active) begin
            if (!i_s_valid) begin
              w_under     = 1'b1;
              w_state_nxt = ST_SEEK;
            end else if (w_first != i_s_sof) begin
              w_serr      = 1'b1;
              w_state_nxt = ST_SEEK;
            end else begin
              w_take = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_s_ready = w_take || w_drain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_div           <= '0;
      r_h             <= '0;
      r_v             <= '0;
      r_pclk          <= 1'b0;
      r_disp          <= 1'b0;
      r_hsync         <= 1'b1;
      r_vsync         <= 1'b1;
      r_de            <= 1'b0;
      r_rgb           <= '0;
      r_frame_start   <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_sync      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_disp          <= i_en;
      r_frame_start   <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_sync      <= 1'b0;
      if (!w_run) begin
        r_div   <= '0;
        r_h     <= '0;
        r_v     <= '0;
        r_pclk  <= 1'b0;
        r_hsync <= 1'b1;
        r_vsync <= 1'b1;
        r_de    <= 1'b0;
        r_rgb   <= '0;
      end else begin
        r_div  <= (r_div == C_D_LAST) ? '0 : r_div + DW'(1);
        r_pclk <= (r_div < C_D_HALF);
        if (w_pt) begin
          if (r_h == C_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == C_V_LAST) ? '0 : r_v + VW'(1);
          end else begin
            r_h <= r_h + HW'(1);
          end
          r_de            <= w_active;
          r_hsync         <= !((r_h >= C_HS_BEG) && (r_h < C_HS_END));
          r_vsync         <= !((r_v >= C_VS_BEG) && (r_v < C_VS_END));
          r_rgb           <= w_take ? i_s_data : 24'h0;
          r_frame_start   <= w_first;
          r_err_underflow <= w_under;
          r_err_sync      <= w_serr;
        end
      end
    end
  end

  assign o_tft_pclk      = r_pclk;
  assign o_tft_disp      = r_disp;
  assign o_tft_hsync     = r_hsync;
  assign o_tft_vsync     = r_vsync;
  assign o_tft_de        = r_de;
  assign o_tft_rgb       = r_rgb;
  assign o_frame_start   = r_frame_start;
  assign o_err_underflow = r_err_underflow;
  assign o_err_sync      = r_err_sync;

endmodule

// File: tb/tb_tft_lcd_timing_gen.sv
// tb/tb_tft_lcd_timing_gen.sv - self-checking bench for tft_lcd_timing_gen on a small 8x6 raster
module tb_tft_lcd_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int DIV = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst, en, s_valid, s_sof;
  logic [23:0] s_data;
  logic        o_s_ready, o_tft_pclk, o_tft_disp, o_tft_hsync, o_tft_vsync, o_tft_de;
  logic [23:0] o_tft_rgb;
  logic        o_frame_start, o_err_underflow, o_err_sync;

  always #5 clk = ~clk;

  tft_lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PCLK_DIV(DIV)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_s_valid(s_valid), .o_s_ready(o_s_ready), .i_s_data(s_data), .i_s_sof(s_sof),
    .o_tft_pclk(o_tft_pclk), .o_tft_disp(o_tft_disp), .o_tft_hsync(o_tft_hsync),
    .o_tft_vsync(o_tft_vsync), .o_tft_de(o_tft_de), .o_tft_rgb(o_tft_rgb),
    .o_frame_start(o_frame_start), .o_err_underflow(o_err_underflow), .o_err_sync(o_err_sync)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Source queue: head drives the stream; gate can withhold valid.
  logic [23:0] q_data[$];
  bit          q_sof[$];
  bit          gate;

  // Reference model: raster position derived from ticks elapsed since the run started.
  int unsigned m_k;
  bit          m_run, m_lock;
  logic        e_ready, e_pclk, e_disp, e_hs, e_vs, e_de, e_fs, e_eu, e_es;
  logic [23:0] e_rgb;

  int          sc_ready, sc_eu, sc_es;
  logic [23:0] cap[$];

  task automatic model_reset_outs();
    e_pclk = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 24'h0;
  endtask

  task automatic model();
    int p, h, v;
    bit pt, first, act, take, under, serr;
    e_ready = 1'b0; e_fs = 1'b0; e_eu = 1'b0; e_es = 1'b0;
    if (rst || !en) begin
      m_run = 0; m_lock = 0; m_k = 0; e_disp = 1'b0;
      model_reset_outs();
    end else if (!m_run) begin
      m_run = 1; m_k = 0; e_disp = 1'b1;
      model_reset_outs();
    end else begin
      p = int'(m_k / DIV);
      pt = (m_k % DIV) == 0;
      h = p % HT;
      v = (p / HT) % VT;
      first = (h == 0) && (v == 0);
      act = (h < HA) && (v < VA);
      take = 0; under = 0; serr = 0;
      if (!m_lock) begin
        if (pt && first && s_valid && s_sof) begin
          take = 1; m_lock = 1;
        end else begin
          e_ready = s_valid && !s_sof;
        end
      end else if (pt && act) begin
        if (!s_valid) begin
          under = 1; m_lock = 0;
        end else if (s_sof != first) begin
          serr = 1; m_lock = 0;
        end else begin
          take = 1;
        end
      end
      if (take) e_ready = 1'b1;
      e_disp = 1'b1;
      e_pclk = (m_k % DIV) < (DIV / 2);
      if (pt) begin
        e_de  = act;
        e_hs  = !(h >= HA + HF && h < HA + HF + HS);
        e_vs  = !(v >= VA + VF && v < VA + VF + VS);
        e_rgb = take ? s_data : 24'h0;
        e_fs  = first;
        e_eu  = under;
        e_es  = serr;
      end
      m_k++;
    end
  endtask

  task automatic drive();
    s_valid = gate && (q_data.size() > 0);
    s_data  = (q_data.size() > 0) ? q_data[0] : 24'h0;
    s_sof   = (q_sof.size() > 0) ? q_sof[0] : 1'b0;
  endtask

  task automatic step();
    drive();
    #1;
    model();
    chk("s_ready", 32'(o_s_ready), 32'(e_ready));
    if (o_s_ready) sc_ready++;
    @(negedge clk);
    chk("pclk", 32'(o_tft_pclk), 32'(e_pclk));
    chk("disp", 32'(o_tft_disp), 32'(e_disp));
    chk("hsync", 32'(o_tft_hsync), 32'(e_hs));
    chk("vsync", 32'(o_tft_vsync), 32'(e_vs));
    chk("de", 32'(o_tft_de), 32'(e_de));
    chk("rgb", {8'h0, o_tft_rgb}, {8'h0, e_rgb});
    chk("frame_start", 32'(o_frame_start), 32'(e_fs));
    chk("err_underflow", 32'(o_err_underflow), 32'(e_eu));
    chk("err_sync", 32'(o_err_sync), 32'(e_es));
    if (e_ready && q_data.size() > 0) begin
      void'(q_data.pop_front());
      void'(q_sof.pop_front());
    end
    if (o_err_underflow) sc_eu++;
    if (o_err_sync) sc_es++;
    if (o_tft_pclk && o_tft_de) cap.push_back(o_tft_rgb);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; gate = 1'b1;
    q_data.delete(); q_sof.delete();
    step(); step();
    rst = 1'b0;
    step();
    sc_ready = 0; sc_eu = 0; sc_es = 0;
    cap.delete();
  endtask

  task automatic push_px(input logic [23:0] d, input bit sof);
    q_data.push_back(d);
    q_sof.push_back(sof);
  endtask

  task automatic push_frame(input int n);
    for (int i = 1; i <= n; i++) push_px(24'(i), i == 1);
  endtask

  task automatic chk_cap(input string name, input logic [23:0] exp[$]);
    chk({name, "_len"}, 32'(cap.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk(name, {8'h0, cap[i]}, {8'h0, exp[i]});
  endtask

  typedef struct {
    int   n;
    logic pclk, disp, hs, vs, de, fs;
  } tvec_t;
  tvec_t tbl[12];

  initial begin
    logic [23:0] exp_cap[$];
    int idx;
    bit pushed, reached;
    int en_off;

    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 24'h0; gate = 1'b1;
    m_k = 0; m_run = 0; m_lock = 0;
    sc_ready = 0; sc_eu = 0; sc_es = 0;

    tbl[0]  = '{0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{9,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{49, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{65, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{97, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state, then idle raster with no stream against the table.
    do_reset();
    chk("reset_disp", 32'(o_tft_disp), 32'd0);
    chk("reset_hsync", 32'(o_tft_hsync), 32'd1);
    chk("reset_vsync", 32'(o_tft_vsync), 32'd1);
    en = 1'b1;
    idx = 0;
    for (int j = 0; j < 100; j++) begin
      step();
      if (idx < 12 && tbl[idx].n == j) begin
        chk("tbl_pclk", 32'(o_tft_pclk), 32'(tbl[idx].pclk));
        chk("tbl_disp", 32'(o_tft_disp), 32'(tbl[idx].disp));
        chk("tbl_hsync", 32'(o_tft_hsync), 32'(tbl[idx].hs));
        chk("tbl_vsync", 32'(o_tft_vsync), 32'(tbl[idx].vs));
        chk("tbl_de", 32'(o_tft_de), 32'(tbl[idx].de));
        chk("tbl_frame_start", 32'(o_frame_start), 32'(tbl[idx].fs));
        idx++;
      end
    end
    chk("tbl_visited", 32'(idx), 32'd12);
    chk("idle_errors", 32'(sc_eu + sc_es), 32'd0);

    // 12-pixel frame with SOF on the first.
    do_reset();
    push_frame(12);
    en = 1'b1;
    for (int j = 0; j < 96; j++) step();
    exp_cap.delete();
    for (int i = 1; i <= 12; i++) exp_cap.push_back(24'(i));
    chk_cap("frame_rgb", exp_cap);
    chk("frame_ready_cnt", 32'(sc_ready), 32'd12);
    chk("frame_errors", 32'(sc_eu + sc_es), 32'd0);

    // Stall at pixel 6, realign on the next frame's SOF.
    do_reset();
    push_frame(5);
    en = 1'b1;
    pushed = 0;
    for (int j = 0; j < 190; j++) begin
      step();
      if (!pushed && o_err_underflow) begin
        push_frame(12);
        pushed = 1;
      end
    end
    exp_cap.delete();
    for (int i = 1; i <= 5; i++) exp_cap.push_back(24'(i));
    for (int i = 0; i < 7; i++) exp_cap.push_back(24'h0);
    for (int i = 1; i <= 12; i++) exp_cap.push_back(24'(i));
    chk_cap("stall_rgb", exp_cap);
    chk("stall_underflow_cnt", 32'(sc_eu), 32'd1);
    chk("stall_sync_cnt", 32'(sc_es), 32'd0);
    chk("stall_ready_cnt", 32'(sc_ready), 32'd17);

    // Three garbage pixels ahead of the SOF frame are drained.
    do_reset();
    for (int i = 0; i < 3; i++) push_px(24'hAAAAAA, 1'b0);
    push_frame(12);
    en = 1'b1;
    for (int j = 0; j < 190; j++) step();
    exp_cap.delete();
    for (int i = 0; i < 12; i++) exp_cap.push_back(24'h0);
    for (int i = 1; i <= 12; i++) exp_cap.push_back(24'(i));
    chk_cap("garbage_rgb", exp_cap);
    chk("garbage_ready_cnt", 32'(sc_ready), 32'd15);
    chk("garbage_errors", 32'(sc_eu + sc_es), 32'd0);

    // SOF at pixel 5: sync error, pixel held until the next h=0,v=0.
    do_reset();
    for (int i = 1; i <= 12; i++) push_px(24'(i), (i == 1) || (i == 5));
    en = 1'b1;
    for (int j = 0; j < 190; j++) step();
    exp_cap.delete();
    for (int i = 1; i <= 4; i++) exp_cap.push_back(24'(i));
    for (int i = 0; i < 8; i++) exp_cap.push_back(24'h0);
    for (int i = 5; i <= 12; i++) exp_cap.push_back(24'(i));
    for (int i = 0; i < 4; i++) exp_cap.push_back(24'h0);
    chk_cap("sofmis_rgb", exp_cap);
    chk("sofmis_sync_cnt", 32'(sc_es), 32'd1);
    chk("sofmis_underflow_cnt", 32'(sc_eu), 32'd1);
    chk("sofmis_ready_cnt", 32'(sc_ready), 32'd12);

    // Reset landing on the pixel tick of v=1,h=2 mid-stream.
    do_reset();
    push_frame(12);
    en = 1'b1;
    reached = 0;
    for (int j = 0; j < 200 && !reached; j++) begin
      if (m_run && m_k == 20) reached = 1;
      else step();
    end
    chk("rst_point_reached", 32'(reached), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_disp", 32'(o_tft_disp), 32'd0);
    chk("midrst_pclk", 32'(o_tft_pclk), 32'd0);
    chk("midrst_hsync", 32'(o_tft_hsync), 32'd1);
    chk("midrst_vsync", 32'(o_tft_vsync), 32'd1);
    chk("midrst_de", 32'(o_tft_de), 32'd0);
    chk("midrst_rgb", {8'h0, o_tft_rgb}, 32'd0);
    rst = 1'b0;
    drive();
    #1;
    chk("midrst_ready", 32'(o_s_ready), 32'd0);

    // Randomized traffic: gated valid, short/garbage frames, EN drops, rare resets.
    do_reset();
    en = 1'b1;
    en_off = 0;
    for (int j = 0; j < 3000; j++) begin
      if (q_data.size() < 3) begin
        case ($urandom % 8)
          0: for (int i = 0; i < 3; i++) push_px(24'($urandom), 1'b0);
          1: push_frame(11);
          2: push_frame(13);
          default: push_frame(12);
        endcase
      end
      gate = ($urandom % 8) != 0;
      if (en_off > 0) begin
        en_off--;
        en = (en_off == 0);
      end else if ($urandom % 400 == 0) begin
        en_off = 1 + int'($urandom % 5);
        en = 1'b0;
      end
      rst = ($urandom % 1000 == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
